multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control unit for the RV32I core: a state machine that sequences fetch, decode, execute, memory and write-back over several clock cycles. It replaces single-cycle decode, adding memory request/ready handshakes, wait-state timeouts, strict illegal-instruction detection and a retired-instruction counter. It sits between the instruction register and the shared-ALU datapath, driving every datapath mux and write enable.

## Interface
- TIMEOUT_CYCLES, 16: maximum request cycles without ready before a fault; 0 disables the timeout.
- STRICT_DECODE, 1: 1 means undefined func3 on load/store/branch is illegal; 0 means undefined load/store func3 becomes word and branch is accepted.
- CNT_W, 32: width of the instret counter.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  instruction-register opcode.
- func3  in  3  instruction-register func3.
- branch_taken  in  1  comparator result for current rs1/rs2 and func3.
- imem_ready / dmem_ready  in  1  memory accepts/completes the request this cycle.
- imem_req / dmem_req  out  1  memory request, held until ready.
- IRWrite, PCWrite, RegWrite, MemRead, MemWrite  out  1  datapath strobes.
- ALUSrcA  out  2  0 rs1, 1 OldPC, 2 zero.
- ALUSrcB  out  2  0 rs2, 1 imm, 2 constant 4.
- ALUOp  out  2  00 add, 01 branch, 10 R-type, 11 I-type.
- ResultSrc  out  2  0 ALUOut, 1 mem data, 2 PC (already PC+4).
- PCSrc  out  1  0 ALU result, 1 ALUOut register.
- one_byte, two_byte, four_bytes, unsigned_load  out  1  access size, valid in MEM.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  CNT_W  retired count, wraps modulo 2^CNT_W.
- fault  out  1  sticky; high in FAULT.
- fault_cause  out  2  00 none, 01 illegal, 10 imem timeout, 11 dmem timeout.
- state  out  3  current state encoding, for debug.

## Operation
- Moore outputs decoded from state plus opcode/func3; unlisted outputs are 0.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB_ALU=5, WB_MEM=6, FAULT=7.
- IDLE: all outputs 0; go to FETCH next cycle.
- FETCH: imem_req=1, ALUSrcA=1, ALUSrcB=2, PCSrc=0.
  - IRWrite and PCWrite equal imem_ready.
  - On imem_ready, go to DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=1, ALUOp=00; ALUOut captures the branch/JAL target.
  - Illegal opcode/func3 goes to FAULT with cause 01; otherwise go to EXEC.
- EXEC, R-type: A=0, B=0, ALUOp=10, then WB_ALU.
- EXEC, OP-IMM: A=0, B=1, ALUOp=11, then WB_ALU.
- EXEC, LUI: A=2, B=1; AUIPC: A=1, B=1; both ALUOp=00, then WB_ALU.
- EXEC, load/store: A=0, B=1, ALUOp=00, then MEM.
- EXEC, branch: A=0, B=0, ALUOp=01, PCSrc=1, PCWrite=branch_taken, retire=1, then FETCH.
- EXEC, JAL: PCWrite=1, PCSrc=1, RegWrite=1, ResultSrc=2, retire=1, then FETCH.
- EXEC, JALR: A=0, B=1, PCSrc=0, PCWrite=1, RegWrite=1, ResultSrc=2, retire=1, then FETCH.
- MEM: dmem_req=1 and MemRead (load) or MemWrite (store); size flags follow func3.
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Stores: 000, 001, 010.
  - On dmem_ready, a load goes to WB_MEM; a store asserts retire and goes to FETCH.
- WB_ALU: RegWrite=1, ResultSrc=0, retire=1, then FETCH.
- WB_MEM: RegWrite=1, ResultSrc=1, retire=1, then FETCH.
- Timeout:
  - The wait counter clears on entering FETCH/MEM and increments each cycle req=1 and ready=0.
  - If req has been high TIMEOUT_CYCLES cycles with ready still 0 in the last one, go to FAULT with cause 10 (FETCH) or 11 (MEM).
  - Ready in the final cycle wins over the timeout.
- FAULT: all strobes and reqs 0, fault=1, cause held; exits only via rst_n.
- instret increments on each retire and wraps to 0.

## Timing
- rst_n low, asynchronously: state=IDLE, instret=0, fault=0, fault_cause=00, wait counter=0; every output 0. This holds for reset mid-transaction too.
- Latency with zero wait states:
  - branch, JAL, JALR: 3 cycles.
  - R-type, OP-IMM, LUI, AUIPC, store: 4 cycles.
  - load: 5 cycles.
- Each memory wait cycle adds 1.
- Ready is sampled at the edge ending a req-high cycle; req drops the cycle after acceptance.
- retire is asserted in the final cycle of the instruction; instret shows the new value the next cycle.

## Test plan
- Reset release, imem_ready=1, R-type ADD: states 0,1,2,3,5,1; RegWrite high only in WB_ALU; retire once; instret=1.
- LBU with dmem_ready delayed 3 cycles: dmem_req high 4 cycles; one_byte=1 and unsigned_load=1 in MEM; WB_MEM ResultSrc=1; 8 cycles total from FETCH.
- BEQ with branch_taken=0 then 1: PCWrite=0 vs 1 in EXEC with PCSrc=1; both 3 cycles.
- Load with func3=011: STRICT_DECODE=1 gives FAULT, cause 01, no strobes afterwards; STRICT_DECODE=0 gives a four_bytes load.
- imem_ready held 0 with TIMEOUT_CYCLES=16: FAULT after 16 req cycles, cause 10; with ready in the 16th cycle, DECODE is reached instead.
- rst_n pulsed low mid-MEM: dmem_req drops immediately, state=0, instret=0; CNT_W=4 with 16 retires gives instret wrap to 0.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : RV32I multi-cycle control FSM. Sequences fetch, decode, execute,
//            memory and write-back, with memory handshakes, wait-state
//            timeouts, illegal-instruction trapping and a retired counter.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit STRICT_DECODE  = 1'b1,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       i_opcode,
  input  logic [2:0]       i_func3,
  input  logic             i_branch_taken,
  input  logic             i_imem_ready,
  input  logic             i_dmem_ready,
  output logic             o_imem_req,
  output logic             o_dmem_req,
  output logic             o_IRWrite,
  output logic             o_PCWrite,
  output logic             o_RegWrite,
  output logic             o_MemRead,
  output logic             o_MemWrite,
  output logic [1:0]       o_ALUSrcA,
  output logic [1:0]       o_ALUSrcB,
  output logic [1:0]       o_ALUOp,
  output logic [1:0]       o_ResultSrc,
  output logic             o_PCSrc,
  output logic             o_one_byte,
  output logic             o_two_byte,
  output logic             o_four_bytes,
  output logic             o_unsigned_load,
  output logic             o_retire,
  output logic [CNT_W-1:0] o_instret,
  output logic             o_fault,
  output logic [1:0]       o_fault_cause,
  output logic [2:0]       o_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB_ALU = 3'd5,
    S_WB_MEM = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_REG    = 7'b0110011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

  // The counter only has to reach TIMEOUT_CYCLES-1: the last waiting cycle
  // is recognised by value, not by an extra increment.
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] c_WAIT_LAST =
      (TIMEOUT_CYCLES > 0) ? WAIT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit c_TO_EN = (TIMEOUT_CYCLES != 0);

  state_t             r_state;
  logic [WAIT_W-1:0]  r_wait;
  logic [CNT_W-1:0]   r_instret;
  logic               r_fault;
  logic [1:0]         r_cause;

  logic w_is_load, w_is_store, w_is_branch, w_is_jal, w_is_jalr;
  logic w_is_reg, w_is_imm, w_is_lui, w_is_auipc, w_is_alu;
  logic w_load_f3_ok, w_store_f3_ok, w_branch_f3_ok, w_legal;
  logic w_wait_hit, w_retire;

  assign w_is_load   = (i_opcode == c_OP_LOAD);
  assign w_is_store  = (i_opcode == c_OP_STORE);
  assign w_is_branch = (i_opcode == c_OP_BRANCH);
  assign w_is_jal    = (i_opcode == c_OP_JAL);
  assign w_is_jalr   = (i_opcode == c_OP_JALR);
  assign w_is_reg    = (i_opcode == c_OP_REG);
  assign w_is_imm    = (i_opcode == c_OP_IMM);
  assign w_is_lui    = (i_opcode == c_OP_LUI);
  assign w_is_auipc  = (i_opcode == c_OP_AUIPC);
  assign w_is_alu    = w_is_reg || w_is_imm || w_is_lui || w_is_auipc;

  // Defined encodings: loads b/h/w/bu/hu, stores b/h/w, branches all but 010/011.
  assign w_load_f3_ok   = (i_func3 <= 3'b010) || (i_func3 == 3'b100) || (i_func3 == 3'b101);
  assign w_store_f3_ok  = (i_func3 <= 3'b010);
  assign w_branch_f3_ok = (i_func3[2:1] != 2'b01);

  assign w_legal = w_is_alu || w_is_jal || w_is_jalr
                || (w_is_load   && (w_load_f3_ok   || !STRICT_DECODE))
                || (w_is_store  && (w_store_f3_ok  || !STRICT_DECODE))
                || (w_is_branch && (w_branch_f3_ok || !STRICT_DECODE));

  assign w_wait_hit = c_TO_EN && (r_wait == c_WAIT_LAST);

  assign w_retire = ((r_state == S_EXEC) && (w_is_branch || w_is_jal || w_is_jalr))
                 || ((r_state == S_MEM) && w_is_store && i_dmem_ready)
                 || (r_state == S_WB_ALU)
                 || (r_state == S_WB_MEM);

  // State sequencing, wait-state timeout, fault capture and retired counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_instret <= '0;
      r_fault   <= 1'b0;
      r_cause   <= 2'b00;
    end else begin
      // Any state change restarts the wait count; only a stalled request advances it.
      r_wait <= '0;
      if (w_retire) r_instret <= r_instret + 1'b1;
      case (r_state)
        S_IDLE:   r_state <= S_FETCH;
        S_FETCH: begin
          if (i_imem_ready) begin
            r_state <= S_DECODE;
          end else if (w_wait_hit) begin
            r_state <= S_FAULT;
            r_fault <= 1'b1;
            r_cause <= 2'b10;
          end else begin
            r_wait  <= r_wait + 1'b1;
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            r_state <= S_EXEC;
          end else begin
            r_state <= S_FAULT;
            r_fault <= 1'b1;
            r_cause <= 2'b01;
          end
        end
        S_EXEC: begin
          if (w_is_load || w_is_store)                 r_state <= S_MEM;
          else if (w_is_branch || w_is_jal || w_is_jalr) r_state <= S_FETCH;
          else                                          r_state <= S_WB_ALU;
        end
        S_MEM: begin
          if (i_dmem_ready) begin
            r_state <= w_is_store ? S_FETCH : S_WB_MEM;
          end else if (w_wait_hit) begin
            r_state <= S_FAULT;
            r_fault <= 1'b1;
            r_cause <= 2'b11;
          end else begin
            r_wait  <= r_wait + 1'b1;
          end
        end
        S_WB_ALU: r_state <= S_FETCH;
        S_WB_MEM: r_state <= S_FETCH;
        S_FAULT:  r_state <= S_FAULT;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath controls. IRWrite/PCWrite/retire follow same-cycle ready and
  // branch_taken, so they are decoded from the registered state, not stored.
  always_comb begin
    o_imem_req      = 1'b0;
    o_dmem_req      = 1'b0;
    o_IRWrite       = 1'b0;
    o_PCWrite       = 1'b0;
    o_RegWrite      = 1'b0;
    o_MemRead       = 1'b0;
    o_MemWrite      = 1'b0;
    o_ALUSrcA       = 2'd0;
    o_ALUSrcB       = 2'd0;
    o_ALUOp         = 2'b00;
    o_ResultSrc     = 2'd0;
    o_PCSrc         = 1'b0;
    o_one_byte      = 1'b0;
    o_two_byte      = 1'b0;
    o_four_bytes    = 1'b0;
    o_unsigned_load = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_imem_req = 1'b1;
        o_ALUSrcA  = 2'd1;
        o_ALUSrcB  = 2'd2;
        o_IRWrite  = i_imem_ready;
        o_PCWrite  = i_imem_ready;
      end
      S_DECODE: begin
        o_ALUSrcA = 2'd1;
        o_ALUSrcB = 2'd1;
      end
      S_EXEC: begin
        if (w_is_reg) begin
          o_ALUOp = 2'b10;
        end else if (w_is_imm) begin
          o_ALUSrcB = 2'd1;
          o_ALUOp   = 2'b11;
        end else if (w_is_lui) begin
          o_ALUSrcA = 2'd2;
          o_ALUSrcB = 2'd1;
        end else if (w_is_auipc) begin
          o_ALUSrcA = 2'd1;
          o_ALUSrcB = 2'd1;
        end else if (w_is_load || w_is_store) begin
          o_ALUSrcB = 2'd1;
        end else if (w_is_branch) begin
          o_ALUOp   = 2'b01;
          o_PCSrc   = 1'b1;
          o_PCWrite = i_branch_taken;
        end else if (w_is_jal) begin
          o_PCSrc     = 1'b1;
          o_PCWrite   = 1'b1;
          o_RegWrite  = 1'b1;
          o_ResultSrc = 2'd2;
        end else if (w_is_jalr) begin
          o_ALUSrcB   = 2'd1;
          o_PCWrite   = 1'b1;
          o_RegWrite  = 1'b1;
          o_ResultSrc = 2'd2;
        end
      end
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_MemRead  = w_is_load;
        o_MemWrite = w_is_store;
        // Undefined size encodings (lax decode only) fall back to a word access.
        case (i_func3)
          3'b000:  o_one_byte   = 1'b1;
          3'b001:  o_two_byte   = 1'b1;
          3'b100:  begin
            o_one_byte      = w_is_load;
            o_unsigned_load = w_is_load;
            o_four_bytes    = !w_is_load;
          end
          3'b101:  begin
            o_two_byte      = w_is_load;
            o_unsigned_load = w_is_load;
            o_four_bytes    = !w_is_load;
          end
          default: o_four_bytes = 1'b1;
        endcase
      end
      S_WB_ALU: o_RegWrite = 1'b1;
      S_WB_MEM: begin
        o_RegWrite  = 1'b1;
        o_ResultSrc = 2'd1;
      end
      default: ;
    endcase
  end

  assign o_retire      = w_retire;
  assign o_instret     = r_instret;
  assign o_fault       = r_fault;
  assign o_fault_cause = r_cause;
  assign o_state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Self-checking bench for multicycle_control: a transaction-level
//            model expands each instruction into its expected per-cycle
//            outputs; a negedge process compares every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;
  localparam int TO = 16;
  localparam int CW = 4;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam int C_R = 0, C_I = 1, C_LUI = 2, C_AUIPC = 3, C_LD = 4, C_ST = 5;
  localparam int C_BR = 6, C_JAL = 7, C_JALR = 8, C_BAD = 9;

  typedef struct packed {
    logic [2:0] st;
    logic ireq, dreq, irw, pcw, rw, mr, mw;
    logic [1:0] sa, sb, aop, rs;
    logic pcs, b1, b2, b4, us, ret, flt;
    logic [1:0] cause;
    logic [CW-1:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (strict decode, 16-cycle timeout, 4-bit counter)
  logic rst_n, taken, ir, dr;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic ireq, dreq, irw, pcw, rw, mr, mw, pcs, b1, b2, b4, us, ret, flt;
  logic [1:0] sa, sb, aop, rs, cause;
  logic [CW-1:0] cnt;
  logic [2:0] st;

  multicycle_control #(.TIMEOUT_CYCLES(TO), .STRICT_DECODE(1'b1), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_opcode(opcode), .i_func3(func3),
    .i_branch_taken(taken), .i_imem_ready(ir), .i_dmem_ready(dr),
    .o_imem_req(ireq), .o_dmem_req(dreq), .o_IRWrite(irw), .o_PCWrite(pcw),
    .o_RegWrite(rw), .o_MemRead(mr), .o_MemWrite(mw), .o_ALUSrcA(sa), .o_ALUSrcB(sb),
    .o_ALUOp(aop), .o_ResultSrc(rs), .o_PCSrc(pcs), .o_one_byte(b1), .o_two_byte(b2),
    .o_four_bytes(b4), .o_unsigned_load(us), .o_retire(ret), .o_instret(cnt),
    .o_fault(flt), .o_fault_cause(cause), .o_state(st));

  // second DUT: lax decode, timeout disabled
  logic l_rst_n, l_taken, l_ir, l_dr;
  logic [6:0] l_op;
  logic [2:0] l_f3;
  logic l_ireq, l_dreq, l_irw, l_pcw, l_rw, l_mr, l_mw, l_pcs, l_b1, l_b2, l_b4, l_us, l_ret, l_flt;
  logic [1:0] l_sa, l_sb, l_aop, l_rs, l_cause;
  logic [31:0] l_cnt;
  logic [2:0] l_st;

  multicycle_control #(.TIMEOUT_CYCLES(0), .STRICT_DECODE(1'b0), .CNT_W(32)) u_lax (
    .clk(clk), .rst_n(l_rst_n), .i_opcode(l_op), .i_func3(l_f3),
    .i_branch_taken(l_taken), .i_imem_ready(l_ir), .i_dmem_ready(l_dr),
    .o_imem_req(l_ireq), .o_dmem_req(l_dreq), .o_IRWrite(l_irw), .o_PCWrite(l_pcw),
    .o_RegWrite(l_rw), .o_MemRead(l_mr), .o_MemWrite(l_mw), .o_ALUSrcA(l_sa), .o_ALUSrcB(l_sb),
    .o_ALUOp(l_aop), .o_ResultSrc(l_rs), .o_PCSrc(l_pcs), .o_one_byte(l_b1), .o_two_byte(l_b2),
    .o_four_bytes(l_b4), .o_unsigned_load(l_us), .o_retire(l_ret), .o_instret(l_cnt),
    .o_fault(l_flt), .o_fault_cause(l_cause), .o_state(l_st));

  obs_t act;
  assign act = {st, ireq, dreq, irw, pcw, rw, mr, mw, sa, sb, aop, rs,
                pcs, b1, b2, b4, us, ret, flt, cause, cnt};

  // model state
  logic [CW-1:0] m_cnt;
  logic m_flt;
  logic [1:0] m_cause;
  obs_t exp_q[$];
  int trace[$];
  int ncyc;
  int vectors = 0;
  int miscompares = 0;
  logic [6:0] ops [9] = '{OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR};

  // per-cycle comparison against the model's expectation for that cycle
  obs_t ce;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      ce = exp_q.pop_front();
      vectors++;
      if (act !== ce) begin
        miscompares++;
        $display("FAIL cycle@%0t: got state=%0d obs=%h, expected state=%0d obs=%h",
                 $time, act.st, act, ce.st, ce);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got running, expected finished");
    $fatal(1);
  end

  task automatic lit(input string nm, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  function automatic int classify(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_R:     return C_R;
      OP_I:     return C_I;
      OP_LUI:   return C_LUI;
      OP_AUIPC: return C_AUIPC;
      OP_JAL:   return C_JAL;
      OP_JALR:  return C_JALR;
      OP_LD:    return (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5) ? C_LD : C_BAD;
      OP_ST:    return (f3 <= 3'd2) ? C_ST : C_BAD;
      OP_BR:    return (f3 == 3'd2 || f3 == 3'd3) ? C_BAD : C_BR;
      default:  return C_BAD;
    endcase
  endfunction

  function automatic obs_t mk(input logic [2:0] s);
    obs_t e = '0;
    e.st = s; e.cnt = m_cnt; e.flt = m_flt; e.cause = m_cause;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // one cycle: queue its expectation, then advance to just after the next edge
  task automatic cyc(input obs_t e);
    trace.push_back(int'(st));
    exp_q.push_back(e);
    if (e.ret) m_cnt = m_cnt + 1'b1;
    ncyc++;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ir = 1'b0; dr = 1'b0;
    m_cnt = '0; m_flt = 1'b0; m_cause = 2'b00;
    cyc(mk(3'd0));
    cyc(mk(3'd0));
    rst_n = 1'b1;
    cyc(mk(3'd0));
  endtask

  task automatic fault_tail();
    for (int i = 0; i < 3; i++) begin
      ir = 1'($urandom); dr = 1'($urandom);
      cyc(mk(3'd7));
    end
  endtask

  // Expands one instruction: wi/wd are the wait cycles before imem/dmem ready,
  // abort_k >= 0 pulls reset in that MEM cycle. Status: 0 done, 1 fault, 2 reset.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic tk,
                           input int wi, input int wd, input int abort_k, output int stat);
    obs_t e;
    int k, cls;
    logic rdy;
    opcode = op; func3 = f3; taken = tk; dr = 1'b0;
    cls = classify(op, f3);
    stat = 0;
    k = 0;
    forever begin
      rdy = (k == wi); ir = rdy;
      e = mk(3'd1); e.ireq = 1; e.sa = 2'd1; e.sb = 2'd2; e.irw = rdy; e.pcw = rdy;
      cyc(e);
      if (rdy) break;
      k++;
      if (k == TO) begin m_flt = 1; m_cause = 2'b10; stat = 1; ir = 0; return; end
    end
    ir = 1'b0;
    e = mk(3'd2); e.sa = 2'd1; e.sb = 2'd1;
    cyc(e);
    if (cls == C_BAD) begin m_flt = 1; m_cause = 2'b01; stat = 1; return; end
    e = mk(3'd3);
    case (cls)
      C_R:     e.aop = 2'b10;
      C_I:     begin e.sb = 2'd1; e.aop = 2'b11; end
      C_LUI:   begin e.sa = 2'd2; e.sb = 2'd1; end
      C_AUIPC: begin e.sa = 2'd1; e.sb = 2'd1; end
      C_LD, C_ST: e.sb = 2'd1;
      C_BR:    begin e.aop = 2'b01; e.pcs = 1; e.pcw = tk; e.ret = 1; end
      C_JAL:   begin e.pcw = 1; e.pcs = 1; e.rw = 1; e.rs = 2'd2; e.ret = 1; end
      default: begin e.sb = 2'd1; e.pcw = 1; e.rw = 1; e.rs = 2'd2; e.ret = 1; end
    endcase
    cyc(e);
    if (cls == C_BR || cls == C_JAL || cls == C_JALR) return;
    if (cls != C_LD && cls != C_ST) begin
      e = mk(3'd5); e.rw = 1; e.ret = 1;
      cyc(e);
      return;
    end
    k = 0;
    forever begin
      if (k == abort_k) begin do_reset(); stat = 2; return; end
      rdy = (k == wd); dr = rdy;
      e = mk(3'd4); e.dreq = 1; e.mr = (cls == C_LD); e.mw = (cls == C_ST);
      e.ret = rdy && (cls == C_ST);
      case (f3)
        3'd0: e.b1 = 1;
        3'd1: e.b2 = 1;
        3'd4: begin e.b1 = 1; e.us = 1; end
        3'd5: begin e.b2 = 1; e.us = 1; end
        default: e.b4 = 1;
      endcase
      cyc(e);
      if (rdy) break;
      k++;
      if (k == TO) begin m_flt = 1; m_cause = 2'b11; stat = 1; dr = 0; return; end
    end
    dr = 1'b0;
    if (cls == C_LD) begin
      e = mk(3'd6); e.rw = 1; e.rs = 2'd1; e.ret = 1;
      cyc(e);
    end
  endtask

  initial begin
    int s;
    int add_tr[4] = '{1, 2, 3, 5};
    rst_n = 0; opcode = OP_R; func3 = 0; taken = 0; ir = 0; dr = 0;
    l_rst_n = 0; l_op = OP_LD; l_f3 = 3'b011; l_taken = 0; l_ir = 1; l_dr = 1;
    m_cnt = '0; m_flt = 0; m_cause = 0; ncyc = 0;
    tick();
    do_reset();

    // R-type ADD, zero waits
    trace.delete(); ncyc = 0;
    run_instr(OP_R, 3'd0, 1'b0, 0, 0, -1, s);
    lit("add_latency", ncyc, 4);
    for (int i = 0; i < 4; i++) lit($sformatf("add_state%0d", i), trace[i], add_tr[i]);
    lit("add_instret", int'(cnt), 1);
    lit("add_next_fetch", int'(st), 1);

    // LBU with dmem ready after 3 wait cycles
    ncyc = 0;
    run_instr(OP_LD, 3'd4, 1'b0, 0, 3, -1, s);
    lit("lbu_latency", ncyc, 8);

    // BEQ not taken, then taken
    ncyc = 0; run_instr(OP_BR, 3'd0, 1'b0, 0, 0, -1, s); lit("beq_nt_latency", ncyc, 3);
    ncyc = 0; run_instr(OP_BR, 3'd0, 1'b1, 0, 0, -1, s); lit("beq_t_latency", ncyc, 3);
    ncyc = 0; run_instr(OP_JALR, 3'd0, 1'b0, 0, 0, -1, s); lit("jalr_latency", ncyc, 3);
    ncyc = 0; run_instr(OP_ST, 3'd2, 1'b0, 0, 0, -1, s); lit("sw_latency", ncyc, 4);
    ncyc = 0; run_instr(OP_LD, 3'd2, 1'b0, 0, 0, -1, s); lit("lw_latency", ncyc, 5);

    // imem ready in the 16th request cycle beats the timeout
    ncyc = 0; run_instr(OP_I, 3'd0, 1'b0, 15, 0, -1, s); lit("late_ready_latency", ncyc, 19);

    // imem never ready: timeout fault
    ncyc = 0; run_instr(OP_R, 3'd0, 1'b0, 100, 0, -1, s);
    lit("imem_to_status", s, 1); lit("imem_to_cycles", ncyc, 16);
    fault_tail();
    lit("imem_to_cause", int'(cause), 2);
    do_reset();

    // load func3=011 is illegal under strict decode
    run_instr(OP_LD, 3'd3, 1'b0, 0, 0, -1, s);
    lit("illegal_status", s, 1);
    fault_tail();
    lit("illegal_cause", int'(cause), 1);
    do_reset();

    // reset in the middle of a waiting MEM phase
    run_instr(OP_JAL, 3'd0, 1'b0, 0, 0, -1, s);
    run_instr(OP_LD, 3'd0, 1'b0, 0, 6, 2, s);
    lit("midmem_status", s, 2); lit("midmem_instret", int'(cnt), 0);

    // 16 retires wrap the 4-bit counter
    for (int i = 0; i < 16; i++) run_instr(OP_JAL, 3'd0, 1'b0, 0, 0, -1, s);
    lit("instret_wrap", int'(cnt), 0);

    // randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      logic [6:0] op;
      int wi, wd, ab;
      op = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 99) < 5) op = 7'($urandom);
      wi = ($urandom_range(0, 11) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 2);
      wd = ($urandom_range(0, 11) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 3);
      ab = ($urandom_range(0, 29) == 0) ? $urandom_range(0, wd) : -1;
      run_instr(op, 3'($urandom), 1'($urandom), wi, wd, ab, s);
      if (s == 1) begin
        fault_tail();
        do_reset();
      end
    end

    // lax decode: load func3=011 becomes a word load, branch func3=010 accepted,
    // timeout disabled
    tick();
    l_rst_n = 1;
    lit("lax_idle", int'(l_st), 0);
    tick(); lit("lax_fetch", int'(l_st), 1);
    tick(); lit("lax_decode", int'(l_st), 2);
    tick(); lit("lax_exec", int'(l_st), 3);
    tick(); lit("lax_mem", int'(l_st), 4);
    lit("lax_four_bytes", int'(l_b4), 1); lit("lax_memread", int'(l_mr), 1);
    tick(); lit("lax_wb_mem", int'(l_st), 6);
    tick(); lit("lax_fetch2", int'(l_st), 1);
    l_op = OP_BR; l_f3 = 3'b010;
    tick(); lit("lax_br_decode", int'(l_st), 2);
    tick(); lit("lax_br_exec", int'(l_st), 3);
    l_ir = 0;
    tick(); lit("lax_fetch3", int'(l_st), 1);
    repeat (40) tick();
    lit("lax_no_timeout_state", int'(l_st), 1);
    lit("lax_no_timeout_fault", int'(l_flt), 0);
    lit("lax_instret", int'(l_cnt), 2);

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
